// File: rtl/lcd_fill_if.sv
// ============================================================================
//  Module   : lcd_fill_if
//  Purpose  : Fill-request and SPI byte-writer handshake bundle for lcd_fill_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_fill_if;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_x0;
    logic [7:0]  req_x1;
    logic [7:0]  req_y0;
    logic [7:0]  req_y1;
    logic [15:0] req_color;
    logic        wr_done;
    logic [8:0]  lcd_data;
    logic        en_write;
    logic        busy;
    logic        fill_done;
    logic        req_err;

    modport master (
        output init_done, req_valid, req_x0, req_x1, req_y0, req_y1, req_color, wr_done,
        input  req_ready, lcd_data, en_write, busy, fill_done, req_err
    );

    modport slave (
        input  init_done, req_valid, req_x0, req_x1, req_y0, req_y1, req_color, wr_done,
        output req_ready, lcd_data, en_write, busy, fill_done, req_err
    );
endinterface

`default_nettype wire

// File: rtl/lcd_fill_ctrl.sv
// ============================================================================
//  Module   : lcd_fill_ctrl
//  Purpose  : Sequences CASET/RASET/RAMWR and pixel bytes for one rectangle fill.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_fill_ctrl #(
    parameter logic [7:0] WIDTH  = 8'd162,
    parameter logic [7:0] HEIGHT = 8'd132
) (
    input  wire logic   sys_clk,
    input  wire logic   sys_rst,
    lcd_fill_if.slave   bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CHECK  = 3'd1;
    localparam logic [2:0] c_ST_CASET  = 3'd2;
    localparam logic [2:0] c_ST_RASET  = 3'd3;
    localparam logic [2:0] c_ST_RAMWR  = 3'd4;
    localparam logic [2:0] c_ST_PIX_HI = 3'd5;
    localparam logic [2:0] c_ST_PIX_LO = 3'd6;
    localparam logic [2:0] c_ST_DONE   = 3'd7;

    localparam logic [8:0] c_DATA_IDLE = 9'h100;
    localparam logic [7:0] c_CMD_CASET = 8'h2A;
    localparam logic [7:0] c_CMD_RASET = 8'h2B;
    localparam logic [7:0] c_CMD_RAMWR = 8'h2C;
    localparam logic [2:0] c_LAST_IDX  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_x0, r_x1, r_y0, r_y1;
    logic [15:0] r_color;
    logic [2:0]  r_idx;
    logic [17:0] r_pix_cnt;
    logic [8:0]  r_lcd_data;
    logic        r_en_write;
    logic [8:0]  w_lcd_data_nxt;
    logic        w_en_write_nxt;

    logic        w_accept;
    logic        w_valid;
    logic [8:0]  w_cols;
    logic [8:0]  w_rows;
    logic [17:0] w_pix_total;
    logic        w_last_pix;
    logic [2:0]  w_idx_inc;

    assign w_accept    = (r_state == c_ST_IDLE) && bus.req_valid && bus.init_done;
    assign w_valid     = (r_x0 <= r_x1) && (r_y0 <= r_y1) && (r_x1 <= WIDTH) && (r_y1 <= HEIGHT);
    assign w_cols      = {1'b0, r_x1} - {1'b0, r_x0} + 9'd1;
    assign w_rows      = {1'b0, r_y1} - {1'b0, r_y0} + 9'd1;
    assign w_pix_total = {9'd0, w_cols} * {9'd0, w_rows};
    assign w_last_pix  = (r_pix_cnt == 18'd1);
    assign w_idx_inc   = r_idx + 3'd1;

    // Window-set sequence: cmd, 00, start, 00, end
    function automatic logic [8:0] f_win_byte(input logic [2:0] idx, input logic [7:0] cmd,
                                              input logic [7:0] lo, input logic [7:0] hi);
        case (idx)
            3'd0:    f_win_byte = {1'b0, cmd};
            3'd2:    f_win_byte = {1'b1, lo};
            3'd4:    f_win_byte = {1'b1, hi};
            default: f_win_byte = c_DATA_IDLE;
        endcase
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= c_ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_nxt = c_ST_CHECK;
            c_ST_CHECK:  w_state_nxt = w_valid ? c_ST_CASET : c_ST_IDLE;
            c_ST_CASET:  if (bus.wr_done && (r_idx == c_LAST_IDX)) w_state_nxt = c_ST_RASET;
            c_ST_RASET:  if (bus.wr_done && (r_idx == c_LAST_IDX)) w_state_nxt = c_ST_RAMWR;
            c_ST_RAMWR:  if (bus.wr_done) w_state_nxt = c_ST_PIX_HI;
            c_ST_PIX_HI: if (bus.wr_done) w_state_nxt = c_ST_PIX_LO;
            c_ST_PIX_LO: if (bus.wr_done) w_state_nxt = w_last_pix ? c_ST_DONE : c_ST_PIX_HI;
            c_ST_DONE:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Status flags plus the byte to present once the current one is acknowledged
    always_comb begin
        bus.req_ready  = (r_state == c_ST_IDLE) && bus.init_done;
        bus.busy       = (r_state != c_ST_IDLE);
        bus.fill_done  = (r_state == c_ST_DONE);
        bus.req_err    = (r_state == c_ST_CHECK) && !w_valid;
        w_lcd_data_nxt = r_lcd_data;
        w_en_write_nxt = r_en_write;
        case (r_state)
            c_ST_CHECK: begin
                if (w_valid) begin
                    w_lcd_data_nxt = {1'b0, c_CMD_CASET};
                    w_en_write_nxt = 1'b1;
                end
            end
            c_ST_CASET: begin
                if (bus.wr_done)
                    w_lcd_data_nxt = (r_idx == c_LAST_IDX) ? {1'b0, c_CMD_RASET}
                                   : f_win_byte(w_idx_inc, c_CMD_CASET, r_x0, r_x1);
            end
            c_ST_RASET: begin
                if (bus.wr_done)
                    w_lcd_data_nxt = (r_idx == c_LAST_IDX) ? {1'b0, c_CMD_RAMWR}
                                   : f_win_byte(w_idx_inc, c_CMD_RASET, r_y0, r_y1);
            end
            c_ST_RAMWR: begin
                if (bus.wr_done) w_lcd_data_nxt = {1'b1, r_color[15:8]};
            end
            c_ST_PIX_HI: begin
                if (bus.wr_done) w_lcd_data_nxt = {1'b1, r_color[7:0]};
            end
            c_ST_PIX_LO: begin
                if (bus.wr_done) begin
                    if (w_last_pix) begin
                        w_lcd_data_nxt = c_DATA_IDLE;
                        w_en_write_nxt = 1'b0;
                    end else begin
                        w_lcd_data_nxt = {1'b1, r_color[15:8]};
                    end
                end
            end
            default: begin
                w_lcd_data_nxt = r_lcd_data;
                w_en_write_nxt = r_en_write;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_x0       <= 8'd0;
            r_x1       <= 8'd0;
            r_y0       <= 8'd0;
            r_y1       <= 8'd0;
            r_color    <= 16'd0;
            r_idx      <= 3'd0;
            r_pix_cnt  <= 18'd0;
            r_lcd_data <= c_DATA_IDLE;
            r_en_write <= 1'b0;
        end else begin
            r_lcd_data <= w_lcd_data_nxt;
            r_en_write <= w_en_write_nxt;
            if (w_accept) begin
                r_x0    <= bus.req_x0;
                r_x1    <= bus.req_x1;
                r_y0    <= bus.req_y0;
                r_y1    <= bus.req_y1;
                r_color <= bus.req_color;
            end
            if (((r_state == c_ST_CASET) || (r_state == c_ST_RASET)) && bus.wr_done)
                r_idx <= (r_idx == c_LAST_IDX) ? 3'd0 : w_idx_inc;
            if ((r_state == c_ST_CHECK) && w_valid)
                r_pix_cnt <= w_pix_total;
            else if ((r_state == c_ST_PIX_LO) && bus.wr_done)
                r_pix_cnt <= r_pix_cnt - 18'd1;
        end
    end

    assign bus.lcd_data = r_lcd_data;
    assign bus.en_write = r_en_write;

endmodule

`default_nettype wire

// File: tb/tb_lcd_fill_ctrl.sv
// ============================================================================
//  Module   : tb_lcd_fill_ctrl
//  Purpose  : Randomised self-checking bench for lcd_fill_ctrl against a byte-queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_fill_ctrl;

    localparam int c_W = 162;
    localparam int c_H = 132;

    logic clk;
    logic rst;
    bit   fast;

    lcd_fill_if bus ();

    lcd_fill_ctrl #(.WIDTH(8'd162), .HEIGHT(8'd132)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Model: phase 0 idle, 1 check, 2 streaming, 3 done
    int          ph = 0;
    bit          m_ok = 1'b0;
    bit          clean = 1'b1;
    logic [8:0]  q[$];
    logic [8:0]  gq[$];
    int          cyc = 0;
    int          acc_count = 0;
    int          accept_cyc = 0;
    int          consumed = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;
    int          dut_fills = 0;
    int          dut_errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic gen_bytes(input int x0, input int x1, input int y0, input int y1, input int c);
        int n;
        gq.delete();
        gq.push_back(9'h02A); gq.push_back(9'h100); gq.push_back(9'(256 + x0));
        gq.push_back(9'h100); gq.push_back(9'(256 + x1));
        gq.push_back(9'h02B); gq.push_back(9'h100); gq.push_back(9'(256 + y0));
        gq.push_back(9'h100); gq.push_back(9'(256 + y1));
        gq.push_back(9'h02C);
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int i = 0; i < n; i++) begin
            gq.push_back(9'(256 + ((c >> 8) & 255)));
            gq.push_back(9'(256 + (c & 255)));
        end
    endtask

    // SPI byte writer stand-in
    always @(posedge clk) begin
        #1;
        if (rst)           bus.wr_done = 1'b0;
        else if (fast)     bus.wr_done = bus.en_write;
        else if (bus.en_write) bus.wr_done = ($urandom_range(0, 2) == 0);
        else               bus.wr_done = ($urandom_range(0, 7) == 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_busy",      32'(bus.busy),      32'd0);
            chk("rst_en_write",  32'(bus.en_write),  32'd0);
            chk("rst_lcd_data",  32'(bus.lcd_data),  32'h100);
            chk("rst_fill_done", 32'(bus.fill_done), 32'd0);
            chk("rst_req_err",   32'(bus.req_err),   32'd0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'(bus.init_done));
            ph = 0;
            q.delete();
            clean = 1'b1;
        end else begin
            chk("busy",      32'(bus.busy),      32'(ph != 0));
            chk("en_write",  32'(bus.en_write),  32'(ph == 2));
            chk("fill_done", 32'(bus.fill_done), 32'(ph == 3));
            chk("req_err",   32'(bus.req_err),   32'(ph == 1 && !m_ok));
            chk("req_ready", 32'(bus.req_ready), 32'(ph == 0 && bus.init_done));
            if (ph == 2) begin
                if (q.size() == 0) chk("stream_empty", 32'(q.size()), 32'd1);
                else               chk("lcd_data", 32'(bus.lcd_data), 32'(q[0]));
            end else if (clean) begin
                chk("lcd_idle", 32'(bus.lcd_data), 32'h100);
            end
            if (bus.fill_done) begin dut_fills++; done_cyc = cyc; end
            if (bus.req_err)   dut_errs++;
            case (ph)
                0: if (bus.req_valid && bus.init_done) begin
                    m_ok = (bus.req_x0 <= bus.req_x1) && (bus.req_y0 <= bus.req_y1) &&
                           (int'(bus.req_x1) <= c_W) && (int'(bus.req_y1) <= c_H);
                    q.delete();
                    if (m_ok) begin
                        gen_bytes(int'(bus.req_x0), int'(bus.req_x1), int'(bus.req_y0),
                                  int'(bus.req_y1), int'(bus.req_color));
                        q = gq;
                    end
                    consumed = 0;
                    acc_count++;
                    accept_cyc = cyc;
                    ph = 1;
                end
                1: ph = m_ok ? 2 : 0;
                2: if (bus.wr_done) begin
                    if (q.size() > 0) void'(q.pop_front());
                    consumed++;
                    last_wr_cyc = cyc;
                    if (q.size() == 0) ph = 3;
                end
                default: begin ph = 0; clean = 1'b0; end
            endcase
        end
    end

    task automatic do_req(input int x0, input int x1, input int y0, input int y1, input int c);
        int snap;
        bit got;
        snap = acc_count;
        got  = 1'b0;
        bus.req_x0    = 8'(x0);
        bus.req_x1    = 8'(x1);
        bus.req_y0    = 8'(y0);
        bus.req_y1    = 8'(y1);
        bus.req_color = 16'(c);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            if (acc_count != snap) begin got = 1'b1; break; end
        end
        if (!got) chk("accept_timeout", 32'(acc_count), 32'(snap + 1));
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (ph == 0) begin got = 1'b1; break; end
        end
        if (!got) chk("idle_timeout", 32'(ph), 32'd0);
        #1;
    endtask

    logic [8:0] c_single [13] = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B, 9'h100,
                                  9'h107, 9'h100, 9'h107, 9'h02C, 9'h1F8, 9'h110};

    initial begin
        int f0, e0, exp_acc, x0, x1, y0, y1, kind, acc2;
        bit found;
        rst = 1'b1;
        fast = 1'b0;
        bus.init_done = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_x0 = 8'd0; bus.req_x1 = 8'd0; bus.req_y0 = 8'd0; bus.req_y1 = 8'd0;
        bus.req_color = 16'd0;

        // Pin the model against hand-derived streams
        gen_bytes(5, 5, 7, 7, 16'hF810);
        chk("pin_single_len", 32'(gq.size()), 32'd13);
        for (int i = 0; i < 13; i++) chk("pin_single_byte", 32'(gq[i]), 32'(c_single[i]));
        gen_bytes(0, 162, 0, 132, 16'hAF7D);
        chk("pin_full_len", 32'(gq.size()), 32'd43369);
        chk("pin_full_last", 32'(gq[43368]), 32'h17D);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_lcd_data", 32'(bus.lcd_data), 32'h100);
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Request held while init_done is low
        bus.req_x0 = 8'd5; bus.req_x1 = 8'd5; bus.req_y0 = 8'd7; bus.req_y1 = 8'd7;
        bus.req_color = 16'hF810; bus.req_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("gated_no_accept", 32'(acc_count), 32'd0);
        bus.init_done = 1'b1;
        exp_acc = cyc + 1;
        f0 = dut_fills;
        do_req(5, 5, 7, 7, 16'hF810);
        chk("accept_on_init_rise", 32'(accept_cyc), 32'(exp_acc));
        bus.req_valid = 1'b0;
        wait_idle(500);
        chk("single_wr_done_count", 32'(consumed), 32'd13);
        chk("single_done_latency", 32'(done_cyc), 32'(last_wr_cyc + 1));
        chk("single_fill_pulses", 32'(dut_fills - f0), 32'd1);

        // Invalid request x0 > x1
        e0 = dut_errs; f0 = dut_fills;
        do_req(10, 4, 0, 0, 16'h1234);
        bus.req_valid = 1'b0;
        wait_idle(50);
        chk("invalid_err_pulses", 32'(dut_errs - e0), 32'd1);
        chk("invalid_no_fill", 32'(dut_fills - f0), 32'd0);
        chk("invalid_no_bytes", 32'(consumed), 32'd0);

        // Coordinate limits: {x0,x1,y0,y1,expect_err}
        for (int k = 0; k < 4; k++) begin
            int tb_x0, tb_x1, tb_y0, tb_y1, tb_err;
            case (k)
                0:       begin tb_x0 = 160; tb_x1 = 162; tb_y0 = 130; tb_y1 = 132; tb_err = 0; end
                1:       begin tb_x0 = 160; tb_x1 = 163; tb_y0 = 0;   tb_y1 = 0;   tb_err = 1; end
                2:       begin tb_x0 = 0;   tb_x1 = 0;   tb_y0 = 130; tb_y1 = 133; tb_err = 1; end
                default: begin tb_x0 = 162; tb_x1 = 162; tb_y0 = 132; tb_y1 = 132; tb_err = 0; end
            endcase
            e0 = dut_errs; f0 = dut_fills;
            do_req(tb_x0, tb_x1, tb_y0, tb_y1, 16'h0F0F);
            bus.req_valid = 1'b0;
            wait_idle(2000);
            chk("limit_err", 32'(dut_errs - e0), 32'(tb_err));
            chk("limit_fill", 32'(dut_fills - f0), 32'(1 - tb_err));
        end

        // Full screen at one byte per cycle
        fast = 1'b1;
        f0 = dut_fills;
        do_req(0, 162, 0, 132, 16'hAF7D);
        bus.req_valid = 1'b0;
        wait_idle(60000);
        chk("full_wr_done_count", 32'(consumed), 32'd43369);
        chk("full_fill_pulses", 32'(dut_fills - f0), 32'd1);
        fast = 1'b0;

        // Reset while a low pixel byte is outstanding
        do_req(0, 3, 0, 3, 16'h1234);
        bus.req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (ph == 2 && bus.lcd_data == 9'h134 && !bus.wr_done) begin found = 1'b1; break; end
        end
        chk("reach_pix_lo", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_en_write", 32'(bus.en_write), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_lcd_data", 32'(bus.lcd_data), 32'h100);
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(5, 5, 7, 7, 16'hF810);
        bus.req_valid = 1'b0;
        wait_idle(500);
        chk("post_rst_wr_done_count", 32'(consumed), 32'd13);

        // Back-to-back: second request held through the first fill
        do_req(2, 5, 3, 4, 16'hF00F);
        do_req(7, 8, 9, 9, 16'h5A5A);
        acc2 = accept_cyc;
        bus.req_valid = 1'b0;
        chk("b2b_accept_after_done", 32'(acc2), 32'(done_cyc + 1));
        wait_idle(1000);
        chk("b2b_second_count", 32'(consumed), 32'd15);

        // Random windows, some invalid, init_done sometimes dropped mid-fill
        for (int n = 0; n < 25; n++) begin
            kind = $urandom_range(0, 4);
            x0 = $urandom_range(0, c_W); x1 = x0 + $urandom_range(0, 5); if (x1 > c_W) x1 = c_W;
            y0 = $urandom_range(0, c_H); y1 = y0 + $urandom_range(0, 5); if (y1 > c_H) y1 = c_H;
            if (kind == 0) begin
                case ($urandom_range(0, 3))
                    0:       begin x1 = $urandom_range(0, c_W - 1); x0 = x1 + 1; end
                    1:       begin y1 = $urandom_range(0, c_H - 1); y0 = y1 + 1; end
                    2:       x1 = $urandom_range(c_W + 1, 255);
                    default: y1 = $urandom_range(c_H + 1, 255);
                endcase
            end
            do_req(x0, x1, y0, y1, int'($urandom_range(0, 65535)));
            bus.req_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) bus.init_done = 1'b0;
            wait_idle(3000);
            bus.init_done = 1'b1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
